// File: rtl/asic_cfg_loader.sv
// Serial configuration loader: shifts a dynamic and an optional static word into an ASIC, MSB first.
// Define ASIC_CFG_LOADER_READBACK_EN to add MISO capture of the static chain (RDBK_DATA/RDBK_VALID).
module asic_cfg_loader #(
   parameter int DYN_W      = 16,
   parameter int STAT_W     = 88,
   parameter int CLK_DIV    = 4,
   parameter int GUARD_BITS = 60
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              MODE,
   input  logic [DYN_W-1:0]  DYN_DATA,
   input  logic [STAT_W-1:0] STAT_DATA,
   output logic              SCLK,
   output logic              SEL,
   output logic              MOSI,
   output logic              BUSY,
   output logic              DONE
`ifdef ASIC_CFG_LOADER_READBACK_EN
   ,
   input  logic              MISO,
   output logic [STAT_W-1:0] RDBK_DATA,
   output logic              RDBK_VALID
`endif
);

   localparam int MAX_DS  = (DYN_W > STAT_W) ? DYN_W : STAT_W;
   localparam int BIT_MAX = (GUARD_BITS > MAX_DS) ? GUARD_BITS : MAX_DS;
   localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int HALF    = CLK_DIV / 2;

   typedef enum logic [2:0] {ST_IDLE, ST_GUARD, ST_DYN, ST_STAT, ST_DONE} stateT;

   stateT             stateReg, stateNext;
   logic [DIV_W-1:0]  divReg, divNext;
   logic [BIT_W-1:0]  bitReg, bitNext;
   logic              modeReg, modeNext;
   logic [DYN_W-1:0]  dynReg, dynNext;
   logic [STAT_W-1:0] statReg, statNext;
   logic              sclkNext, selNext, mosiNext, busyNext, doneNext;
   logic              divEnd;

   assign divEnd = (divReg == DIV_W'(CLK_DIV - 1));

   always_comb begin
      stateNext = stateReg;
      divNext   = divEnd ? '0 : divReg + 1'b1;
      bitNext   = divEnd ? bitReg + 1'b1 : bitReg;
      modeNext  = modeReg;
      dynNext   = dynReg;
      statNext  = statReg;
      case (stateReg)
         ST_IDLE: begin
            divNext = '0;
            bitNext = '0;
            if (START) begin
               stateNext = ST_GUARD;
               modeNext  = MODE;
               dynNext   = DYN_DATA;
               statNext  = STAT_DATA;
            end
         end
         ST_GUARD: begin
            if (divEnd && bitReg == BIT_W'(GUARD_BITS - 1)) begin
               stateNext = ST_DYN;
               bitNext   = '0;
            end
         end
         ST_DYN: begin
            if (divEnd) begin
               dynNext = {dynReg[DYN_W-2:0], 1'b0};
               if (bitReg == BIT_W'(DYN_W - 1)) begin
                  stateNext = modeReg ? ST_DONE : ST_STAT;
                  bitNext   = '0;
               end
            end
         end
         ST_STAT: begin
            if (divEnd) begin
               statNext = {statReg[STAT_W-2:0], 1'b0};
               if (bitReg == BIT_W'(STAT_W - 1)) begin
                  stateNext = ST_DONE;
                  bitNext   = '0;
               end
            end
         end
         ST_DONE: begin
            stateNext = ST_IDLE;
            divNext   = '0;
            bitNext   = '0;
         end
         default: begin
            stateNext = ST_IDLE;
            divNext   = '0;
            bitNext   = '0;
         end
      endcase

      // Outputs are decoded from next-state values so every pin comes straight from a flop.
      sclkNext = (stateNext == ST_DYN || stateNext == ST_STAT) && (divNext >= DIV_W'(HALF));
      selNext  = (stateNext == ST_DYN);
      mosiNext = 1'b0;
      if (stateNext == ST_DYN)
         mosiNext = dynNext[DYN_W-1];
      else if (stateNext == ST_STAT)
         mosiNext = statNext[STAT_W-1];
      busyNext = (stateNext != ST_IDLE);
      doneNext = (stateNext == ST_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stateReg <= ST_IDLE;
         divReg   <= '0;
         bitReg   <= '0;
         modeReg  <= 1'b0;
         dynReg   <= '0;
         statReg  <= '0;
         SCLK     <= 1'b0;
         SEL      <= 1'b0;
         MOSI     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         stateReg <= stateNext;
         divReg   <= divNext;
         bitReg   <= bitNext;
         modeReg  <= modeNext;
         dynReg   <= dynNext;
         statReg  <= statNext;
         SCLK     <= sclkNext;
         SEL      <= selNext;
         MOSI     <= mosiNext;
         BUSY     <= busyNext;
         DONE     <= doneNext;
      end
   end

`ifdef ASIC_CFG_LOADER_READBACK_EN
   logic [STAT_W-1:0] rdbkReg;
   logic              rdbkValidReg;

   // MISO is captured in the cycle SCLK sits high for the first time in each static bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdbkReg      <= '0;
         rdbkValidReg <= 1'b0;
      end else begin
         if (stateReg == ST_IDLE && START)
            rdbkReg <= '0;
         else if (stateReg == ST_STAT && divReg == DIV_W'(HALF))
            rdbkReg <= {rdbkReg[STAT_W-2:0], MISO};
         rdbkValidReg <= (stateNext == ST_DONE) && !modeReg;
      end
   end

   assign RDBK_DATA  = rdbkReg;
   assign RDBK_VALID = rdbkValidReg;
`endif

endmodule

// File: tb/tb_asic_cfg_loader.sv
// Directed self-checking bench for asic_cfg_loader (DYN_W=16, STAT_W=88, CLK_DIV=4, GUARD_BITS=2).
module tb_asic_cfg_loader;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        MODE = 1'b0;
   logic [15:0] DYN_DATA = '0;
   logic [87:0] STAT_DATA = '0;
   logic        SCLK, SEL, MOSI, BUSY, DONE;
`ifdef ASIC_CFG_LOADER_READBACK_EN
   logic        MISO = 1'b0;
   logic [87:0] RDBK_DATA;
   logic        RDBK_VALID;
`endif

   localparam logic [87:0] STAT_A = 88'h123456789ABCDEF1234567;
   localparam logic [87:0] MISO_PAT = 88'hFF00FF00FF00FF00FF00FF;

   int checks = 0;
   int failures = 0;

   int busyCnt, riseCnt, dynRise, statRise, doneCnt, guardBad, doneBad, firstRise, rdbkValidCnt;
   logic [15:0] dynGot;
   logic [87:0] statGot, rdbkGot;
   logic        aborted;

   asic_cfg_loader #(
      .DYN_W(16), .STAT_W(88), .CLK_DIV(4), .GUARD_BITS(2)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
      .DYN_DATA(DYN_DATA), .STAT_DATA(STAT_DATA),
      .SCLK(SCLK), .SEL(SEL), .MOSI(MOSI), .BUSY(BUSY), .DONE(DONE)
`ifdef ASIC_CFG_LOADER_READBACK_EN
      , .MISO(MISO), .RDBK_DATA(RDBK_DATA), .RDBK_VALID(RDBK_VALID)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Observes one transfer from the first BUSY cycle; optionally rewrites DYN_DATA or fires RST mid-STAT.
   task automatic monitor(input int rstAtStatBit, input int chgAt, input logic [15:0] chgDyn);
      logic        prevSclk, prevSel;
      logic [87:0] misoModel;
      busyCnt = 0; riseCnt = 0; dynRise = 0; statRise = 0; doneCnt = 0;
      guardBad = 0; doneBad = 0; firstRise = 0; rdbkValidCnt = 0;
      dynGot = '0; statGot = '0; rdbkGot = '0; aborted = 1'b0;
      prevSclk = 1'b0; prevSel = 1'b0;
      misoModel = MISO_PAT;
`ifdef ASIC_CFG_LOADER_READBACK_EN
      MISO = misoModel[87];
`endif
      while (BUSY && busyCnt < 5000) begin
         busyCnt++;
         if (busyCnt <= 8 && (SCLK || SEL || MOSI)) guardBad++;
         if (DONE) begin
            doneCnt++;
            if (SCLK || SEL || MOSI) doneBad++;
`ifdef ASIC_CFG_LOADER_READBACK_EN
            if (RDBK_VALID) begin
               rdbkValidCnt++;
               rdbkGot = RDBK_DATA;
            end
`endif
         end
         if (SCLK && !prevSclk) begin
            riseCnt++;
            if (firstRise == 0) firstRise = busyCnt;
            if (SEL) begin
               dynRise++;
               dynGot = {dynGot[14:0], MOSI};
            end else begin
               statRise++;
               statGot = {statGot[86:0], MOSI};
            end
         end
`ifdef ASIC_CFG_LOADER_READBACK_EN
         if (prevSclk && !SCLK && !prevSel) begin
            misoModel = {misoModel[86:0], 1'b0};
            MISO = misoModel[87];
         end
`endif
         prevSclk = SCLK;
         prevSel = SEL;
         if (chgAt == busyCnt) DYN_DATA = chgDyn;
         if (rstAtStatBit > 0 && statRise == rstAtStatBit) begin
            RST = 1'b1;
            aborted = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!aborted) chkEq("busy_end", {127'b0, BUSY}, 128'd0);
   endtask

   task automatic verifyXfer(input string tag, input logic m, input logic [15:0] d, input logic [87:0] s);
      $display("xfer %s mode=%0d busy=%0d rises=%0d dyn=%h stat=%h done=%0d",
               tag, m, busyCnt, riseCnt, dynGot, statGot, doneCnt);
      chkEq({tag, "_busy"}, busyCnt, m ? 128'd73 : 128'd425);
      chkEq({tag, "_rises"}, riseCnt, m ? 128'd16 : 128'd104);
      chkEq({tag, "_dyn_rises"}, dynRise, 128'd16);
      chkEq({tag, "_stat_rises"}, statRise, m ? 128'd0 : 128'd88);
      chkEq({tag, "_dyn_data"}, dynGot, d);
      if (!m) chkEq({tag, "_stat_data"}, statGot, s);
      chkEq({tag, "_done"}, doneCnt, 128'd1);
      chkEq({tag, "_guard_quiet"}, guardBad, 128'd0);
      chkEq({tag, "_done_quiet"}, doneBad, 128'd0);
      chkEq({tag, "_first_rise"}, firstRise, 128'd11);
   endtask

   task automatic pulseStart(input logic m, input logic [15:0] d, input logic [87:0] s);
      MODE = m; DYN_DATA = d; STAT_DATA = s; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   initial begin
      int quiet;
      repeat (3) @(negedge CLK);
      chkEq("reset_outputs", {SCLK, SEL, MOSI, BUSY, DONE}, 5'b0);
      RST = 1'b0;
      @(negedge CLK);
      chkEq("idle_busy", {127'b0, BUSY}, 128'd0);

      pulseStart(1'b0, 16'hABC6, STAT_A);
      monitor(0, 0, 16'h0);
      verifyXfer("mode0", 1'b0, 16'hABC6, STAT_A);

      pulseStart(1'b1, 16'hABC6, STAT_A);
      monitor(0, 0, 16'h0);
      verifyXfer("mode1", 1'b1, 16'hABC6, STAT_A);

      pulseStart(1'b0, 16'h8001, 88'h800000000000000000FF01);
      monitor(0, 0, 16'h0);
      verifyXfer("edge_bits", 1'b0, 16'h8001, 88'h800000000000000000FF01);

      // START held high: second transfer is accepted from the IDLE cycle after DONE.
      MODE = 1'b1; DYN_DATA = 16'h1234; START = 1'b1;
      @(negedge CLK);
      monitor(0, 20, 16'hBEEF);
      verifyXfer("b2b_first", 1'b1, 16'h1234, STAT_A);
      chkEq("b2b_gap", {127'b0, BUSY}, 128'd0);
      @(negedge CLK);
      chkEq("b2b_restart", {127'b0, BUSY}, 128'd1);
      START = 1'b0;
      monitor(0, 0, 16'h0);
      verifyXfer("b2b_second", 1'b1, 16'hBEEF, STAT_A);
      @(negedge CLK);
      chkEq("b2b_stop", {127'b0, BUSY}, 128'd0);

      pulseStart(1'b0, 16'hABC6, STAT_A);
      monitor(40, 0, 16'h0);
      chkEq("rst_aborted", {127'b0, aborted}, 128'd1);
      @(negedge CLK);
      chkEq("rst_outputs", {SCLK, SEL, MOSI, BUSY, DONE}, 5'b0);
      RST = 1'b0;
      quiet = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (DONE || BUSY) quiet++;
      end
      chkEq("rst_no_done", quiet, 128'd0);
      $display("xfer reset_abort statbits=40 activity_after=%0d", quiet);

      pulseStart(1'b0, 16'hABC6, STAT_A);
      monitor(0, 0, 16'h0);
      verifyXfer("after_rst", 1'b0, 16'hABC6, STAT_A);

`ifdef ASIC_CFG_LOADER_READBACK_EN
      pulseStart(1'b0, 16'h5A5A, STAT_A);
      monitor(0, 0, 16'h0);
      verifyXfer("rdbk", 1'b0, 16'h5A5A, STAT_A);
      chkEq("rdbk_valid", rdbkValidCnt, 128'd1);
      chkEq("rdbk_data", rdbkGot, MISO_PAT);
      $display("xfer readback data=%h valid=%0d", rdbkGot, rdbkValidCnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/asic_cfg_loader.md
ASIC_CFG_LOADER -- requirements
Module: asic_cfg_loader

Interface
REQ-001 SHALL have parameter DYN_W, default 16: dynamic register length in bits, range 2..64.
REQ-002 SHALL have parameter STAT_W, default 88: static register length in bits, range 2..256.
REQ-003 SHALL have parameter CLK_DIV, default 4: CLK cycles per serial bit period, even, range 2..256.
REQ-004 SHALL have parameter GUARD_BITS, default 60: idle bit periods between START acceptance and the first shifted bit, range 1..16383.
REQ-005 SHALL have port CLK, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port START, input, 1 bit: load request, sampled only in IDLE.
REQ-008 SHALL have port MODE, input, 1 bit: 0 = dynamic then static, 1 = dynamic only; latched with START.
REQ-009 SHALL have port DYN_DATA, input, DYN_W bits: dynamic word, latched with START.
REQ-010 SHALL have port STAT_DATA, input, STAT_W bits: static word, latched with START.
REQ-011 SHALL have port SCLK, output, 1 bit: generated serial clock to the ASIC.
REQ-012 SHALL have port SEL, output, 1 bit: 1 = dynamic register selected, 0 = static.
REQ-013 SHALL have port MOSI, output, 1 bit: serial data, MSB first.
REQ-014 SHALL have port BUSY, output, 1 bit: high from the cycle after START acceptance through the DONE cycle.
REQ-015 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, GUARD, DYN, STAT, DONE; the FSM, counters and outputs SHALL be registered on CLK only, with no second clock domain.
REQ-017 In IDLE with START=1 at edge k, SHALL latch MODE/DYN_DATA/STAT_DATA and enter GUARD at k+1; START in any other state SHALL be ignored and SHALL NOT corrupt latched data.
REQ-018 GUARD SHALL last exactly GUARD_BITS*CLK_DIV cycles with SEL=0, MOSI=0, SCLK=0.
REQ-019 Each bit period in DYN/STAT SHALL be CLK_DIV cycles: SCLK=0 for the first CLK_DIV/2 cycles, SCLK=1 for the remaining CLK_DIV/2; MOSI changes only on the first cycle of a bit period.
REQ-020 DYN SHALL last DYN_W bit periods with SEL=1, shifting DYN_DATA MSB first.
REQ-021 After DYN, MODE=0 SHALL enter STAT; MODE=1 SHALL enter DONE.
REQ-022 STAT SHALL last STAT_W bit periods with SEL=0, shifting STAT_DATA MSB first.
REQ-023 DONE SHALL last one cycle with DONE=1, BUSY=1, SCLK=0, MOSI=0, SEL=0, then return to IDLE; a new START SHALL be accepted from the following IDLE cycle.
REQ-024 Outside DYN/STAT, SCLK SHALL be held 0 and MOSI 0; SCLK SHALL never glitch on state transitions.
REQ-025 Bit and divider counters SHALL be sized ceil(log2) of their maximum count and SHALL clear on every state entry.

Reset
REQ-026 RST=1 at any edge SHALL force IDLE, clear all counters and shift registers, and drive SCLK=0, SEL=0, MOSI=0, BUSY=0, DONE=0 from the next cycle.
REQ-027 Reset mid-transfer SHALL abort without a DONE pulse; the first START after RST deasserts SHALL start a full sequence including GUARD.

Configuration
REQ-028 With macro ASIC_CFG_LOADER_READBACK_EN defined, SHALL add input MISO (1 bit), output RDBK_DATA (STAT_W bits) and output RDBK_VALID (1 bit); MISO SHALL be sampled on the cycle SCLK rises in STAT, shifted into RDBK_DATA LSB-in, and RDBK_VALID SHALL pulse with DONE when MODE=0.
REQ-029 Without ASIC_CFG_LOADER_READBACK_EN, those ports and all readback logic SHALL be absent; remaining behaviour SHALL be identical.

Verification (DYN_W=16, STAT_W=88, CLK_DIV=4, GUARD_BITS=2)
REQ-030 START pulse, MODE=0, DYN_DATA=16'hABC6, STAT_DATA=88'h123456789ABCDEF1234567 -> BUSY high exactly 425 cycles (8+64+352+1), MOSI streams 0xABC6 with SEL=1, then 88'h1234...567 with SEL=0, 104 SCLK rising edges, one DONE pulse.
REQ-031 Same with MODE=1 -> BUSY high 73 cycles, 16 SCLK rising edges, SEL never 0 during shifting, DONE pulse.
REQ-032 START held high continuously -> back-to-back transfers, each preceded by full GUARD; changing DYN_DATA while BUSY does not alter the stream in progress.
REQ-033 RST asserted at bit 40 of STAT -> next cycle all outputs 0, no DONE; later START yields a complete correct 425-cycle transfer.
REQ-034 READBACK_EN defined, MISO looped from a 88-bit model preloaded with 88'hFF00FF00FF00FF00FF00FF -> RDBK_DATA equals that value when RDBK_VALID pulses.
